// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Bundles the Execute -> Memory handshake and the Memory -> Write-back record.
//
// Signals
//   ex_valid      Execute presents a valid operation
//   ex_rd         Execute result; low bits double as the RAM address
//   ex_rb         store data
//   ex_ctrl       {reg_write, mem_read, mem_write, dest[3:0]}
//   mem_ready     memory stage can accept an operation this cycle
//   wb_valid      one-cycle pulse per write-back record
//   wb_data       write-back value
//   wb_dest       destination register
//   wb_reg_write  register-file write enable for the record
//
// Modports
//   master  the Execute / write-back side (drives ex_*, observes the rest)
//   slave   the memory stage itself
// -----------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int DATA_W = 16
);
  logic              ex_valid;
  logic [31:0]       ex_rd;
  logic [DATA_W-1:0] ex_rb;
  logic [6:0]        ex_ctrl;
  logic              mem_ready;
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [3:0]        wb_dest;
  logic              wb_reg_write;

  modport master (
    output ex_valid, ex_rd, ex_rb, ex_ctrl,
    input  mem_ready, wb_valid, wb_data, wb_dest, wb_reg_write
  );

  modport slave (
    input  ex_valid, ex_rd, ex_rb, ex_ctrl,
    output mem_ready, wb_valid, wb_data, wb_dest, wb_reg_write
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the MIPS pipeline. Owns a single-port synchronous
// data RAM, performs loads and stores, passes ALU results through, and emits
// one registered write-back record per accepted operation. Loads take two
// cycles, during which mem_ready drops to stall Execute.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   mem_stage_if.slave: Execute handshake in, write-back record out
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } stateT;

  stateT r_state;
  stateT w_nextState;

  logic [DATA_W-1:0] r_ram [2**ADDR_W];
  logic [DATA_W-1:0] r_rdData;
  logic [3:0]        r_ldDest;
  logic              r_ldRegWrite;

  logic              r_wbValid;
  logic [31:0]       r_wbData;
  logic [3:0]        r_wbDest;
  logic              r_wbRegWrite;

  logic              w_accept;
  logic              w_isStore;
  logic              w_isLoad;
  logic [ADDR_W-1:0] w_addr;

  // An operation is taken only while idle and out of reset; mem_write wins
  // over mem_read, so a word with both bits set is treated as a store.
  assign w_accept  = bus.ex_valid && (r_state == IDLE) && rst;
  assign w_isStore = bus.ex_ctrl[4];
  assign w_isLoad  = bus.ex_ctrl[5] && !bus.ex_ctrl[4];
  assign w_addr    = bus.ex_rd[ADDR_W-1:0];

  assign bus.mem_ready    = (r_state == IDLE);
  assign bus.wb_valid     = r_wbValid;
  assign bus.wb_data      = r_wbData;
  assign bus.wb_dest      = r_wbDest;
  assign bus.wb_reg_write = r_wbRegWrite;

  // State register for the load handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A load parks the stage for exactly one cycle; everything else stays idle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (w_accept && w_isLoad) w_nextState = LOAD_WAIT;
      LOAD_WAIT: w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Data RAM: no reset on the array. w_accept already excludes reset cycles,
  // so a store presented during reset never lands. The read port is
  // registered, and a store on the previous edge is already visible to it.
  always_ff @(posedge clk) begin
    if (w_accept && w_isStore) begin
      r_ram[w_addr] <= bus.ex_rb;
    end
    if (w_accept && w_isLoad) begin
      r_rdData <= r_ram[w_addr];
    end
  end

  // Destination and write enable of an in-flight load, held until the RAM
  // word is available on the following edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ldDest     <= '0;
      r_ldRegWrite <= 1'b0;
    end else if (w_accept && w_isLoad) begin
      r_ldDest     <= bus.ex_ctrl[3:0];
      r_ldRegWrite <= bus.ex_ctrl[6];
    end
  end

  // Write-back record. The valid bit pulses for one cycle per record; the
  // payload holds between records. A load finishing in LOAD_WAIT produces its
  // record from the latched fields; a reset in LOAD_WAIT drops it entirely.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wbValid    <= 1'b0;
      r_wbData     <= '0;
      r_wbDest     <= '0;
      r_wbRegWrite <= 1'b0;
    end else begin
      r_wbValid <= 1'b0;
      if (r_state == LOAD_WAIT) begin
        r_wbValid    <= 1'b1;
        r_wbData     <= 32'(r_rdData);
        r_wbDest     <= r_ldDest;
        r_wbRegWrite <= r_ldRegWrite;
      end else if (w_accept && !w_isLoad) begin
        r_wbValid    <= 1'b1;
        r_wbData     <= bus.ex_rd;
        r_wbDest     <= bus.ex_ctrl[3:0];
        r_wbRegWrite <= bus.ex_ctrl[6] && !w_isStore;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed, self-checking bench for mem_stage. Each task drives one scenario
// and compares the write-back record and mem_ready against hand-computed
// values. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic clk;
  logic rst;
  int   passCount;
  int   checkCount;

  mem_stage_if #(.DATA_W(16)) bus ();

  mem_stage #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one store for a single edge, then drop ex_valid.
  task automatic doStore(input logic [31:0] rd, input logic [15:0] rb);
    bus.ex_valid = 1'b1;
    bus.ex_rd    = rd;
    bus.ex_rb    = rb;
    bus.ex_ctrl  = 7'b001_0000;
    tick();
    bus.ex_valid = 1'b0;
  endtask

  // Drive one load through both of its edges, then drop ex_valid.
  task automatic doLoad(input logic [31:0] rd, input logic [3:0] dest);
    bus.ex_valid = 1'b1;
    bus.ex_rd    = rd;
    bus.ex_ctrl  = {3'b110, dest};
    tick();
    tick();
    bus.ex_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst          = 1'b0;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 32'h0000_0077;
    bus.ex_rb    = 16'h1111;
    bus.ex_ctrl  = 7'b100_0001;
    tick();
    tick();
    checkCount++;
    if (bus.wb_valid !== 1'b0) $display("[TB] FAIL rst_valid got %0b want 0", bus.wb_valid);
    else passCount++;
    checkCount++;
    if (bus.wb_data !== 32'h0) $display("[TB] FAIL rst_data got %h want 0", bus.wb_data);
    else passCount++;
    checkCount++;
    if (bus.wb_dest !== 4'h0 || bus.wb_reg_write !== 1'b0)
      $display("[TB] FAIL rst_dest_rw got %h/%0b want 0/0", bus.wb_dest, bus.wb_reg_write);
    else passCount++;
    checkCount++;
    if (bus.mem_ready !== 1'b1) $display("[TB] FAIL rst_ready got %0b want 1", bus.mem_ready);
    else passCount++;
    bus.ex_valid = 1'b0;
    rst          = 1'b1;
    tick();
  endtask

  task automatic test_passthrough;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 32'h0001_2345;
    bus.ex_ctrl  = 7'b100_0011;
    tick();
    bus.ex_valid = 1'b0;
    checkCount++;
    if (bus.wb_valid !== 1'b1) $display("[TB] FAIL pt_valid got %0b want 1", bus.wb_valid);
    else passCount++;
    checkCount++;
    if (bus.wb_data !== 32'h0001_2345) $display("[TB] FAIL pt_data got %h want 00012345", bus.wb_data);
    else passCount++;
    checkCount++;
    if (bus.wb_dest !== 4'h3 || bus.wb_reg_write !== 1'b1)
      $display("[TB] FAIL pt_dest_rw got %h/%0b want 3/1", bus.wb_dest, bus.wb_reg_write);
    else passCount++;
    checkCount++;
    if (bus.mem_ready !== 1'b1) $display("[TB] FAIL pt_ready got %0b want 1", bus.mem_ready);
    else passCount++;
    tick();
    checkCount++;
    if (bus.wb_valid !== 1'b0) $display("[TB] FAIL pt_pulse got %0b want 0", bus.wb_valid);
    else passCount++;
    checkCount++;
    if (bus.wb_data !== 32'h0001_2345) $display("[TB] FAIL pt_hold got %h want 00012345", bus.wb_data);
    else passCount++;
  endtask

  task automatic test_store_load_fwd;
    doStore(32'h0000_0110, 16'hBEEF);
    checkCount++;
    if (bus.wb_valid !== 1'b1 || bus.wb_reg_write !== 1'b0 || bus.wb_data !== 32'h0000_0110)
      $display("[TB] FAIL st_record got v=%0b rw=%0b d=%h want v=1 rw=0 d=00000110",
               bus.wb_valid, bus.wb_reg_write, bus.wb_data);
    else passCount++;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 32'h0000_0010;
    bus.ex_ctrl  = 7'b110_0101;
    tick();
    checkCount++;
    if (bus.mem_ready !== 1'b0 || bus.wb_valid !== 1'b0)
      $display("[TB] FAIL ld_stall got ready=%0b v=%0b want ready=0 v=0", bus.mem_ready, bus.wb_valid);
    else passCount++;
    tick();
    bus.ex_valid = 1'b0;
    checkCount++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_BEEF)
      $display("[TB] FAIL ld_fwd got v=%0b d=%h want v=1 d=0000beef", bus.wb_valid, bus.wb_data);
    else passCount++;
    checkCount++;
    if (bus.wb_dest !== 4'h5 || bus.wb_reg_write !== 1'b1 || bus.mem_ready !== 1'b1)
      $display("[TB] FAIL ld_fwd_ctl got dest=%h rw=%0b ready=%0b want 5/1/1",
               bus.wb_dest, bus.wb_reg_write, bus.mem_ready);
    else passCount++;
    tick();
  endtask

  task automatic test_store_priority;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 32'h0000_0020;
    bus.ex_rb    = 16'h1234;
    bus.ex_ctrl  = 7'b111_0111;
    tick();
    bus.ex_valid = 1'b0;
    checkCount++;
    if (bus.wb_valid !== 1'b1 || bus.wb_reg_write !== 1'b0 || bus.wb_data !== 32'h0000_0020 ||
        bus.wb_dest !== 4'h7 || bus.mem_ready !== 1'b1)
      $display("[TB] FAIL prio_record got v=%0b rw=%0b d=%h dest=%h ready=%0b want 1/0/00000020/7/1",
               bus.wb_valid, bus.wb_reg_write, bus.wb_data, bus.wb_dest, bus.mem_ready);
    else passCount++;
    tick();
    doLoad(32'h0000_0020, 4'h2);
    checkCount++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_1234 || bus.wb_dest !== 4'h2)
      $display("[TB] FAIL prio_load got v=%0b d=%h dest=%h want 1/00001234/2",
               bus.wb_valid, bus.wb_data, bus.wb_dest);
    else passCount++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] expData [3];
    int          pulses;
    addrs   = '{32'h1, 32'h2, 32'h3};
    expData = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
    doStore(32'h1, 16'h000A);
    doStore(32'h2, 16'h000B);
    doStore(32'h3, 16'h000C);
    pulses       = 0;
    bus.ex_valid = 1'b1;
    bus.ex_ctrl  = 7'b110_1001;
    for (int i = 0; i < 3; i++) begin
      bus.ex_rd = addrs[i];
      tick();
      if (bus.wb_valid === 1'b1) pulses++;
      checkCount++;
      if (bus.mem_ready !== 1'b0) $display("[TB] FAIL b2b_stall%0d got ready=%0b want 0", i, bus.mem_ready);
      else passCount++;
      tick();
      if (bus.wb_valid === 1'b1) pulses++;
      checkCount++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== expData[i] || bus.mem_ready !== 1'b1)
        $display("[TB] FAIL b2b_load%0d got v=%0b d=%h ready=%0b want 1/%h/1",
                 i, bus.wb_valid, bus.wb_data, bus.mem_ready, expData[i]);
      else passCount++;
    end
    bus.ex_valid = 1'b0;
    tick();
    if (bus.wb_valid === 1'b1) pulses++;
    checkCount++;
    if (pulses != 3) $display("[TB] FAIL b2b_pulses got %0d want 3", pulses);
    else passCount++;
  endtask

  task automatic test_reset_abort;
    doStore(32'h0000_0040, 16'h7777);
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 32'h0000_0040;
    bus.ex_ctrl  = 7'b110_0110;
    tick();
    // Load is now in LOAD_WAIT; reset it while presenting a store to 0x40.
    rst          = 1'b0;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 32'h0000_0040;
    bus.ex_rb    = 16'hDEAD;
    bus.ex_ctrl  = 7'b001_0000;
    tick();
    checkCount++;
    if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h0 || bus.wb_dest !== 4'h0 ||
        bus.wb_reg_write !== 1'b0 || bus.mem_ready !== 1'b1)
      $display("[TB] FAIL abort_outputs got v=%0b d=%h dest=%h rw=%0b ready=%0b want 0/0/0/0/1",
               bus.wb_valid, bus.wb_data, bus.wb_dest, bus.wb_reg_write, bus.mem_ready);
    else passCount++;
    rst          = 1'b1;
    bus.ex_valid = 1'b0;
    tick();
    checkCount++;
    if (bus.wb_valid !== 1'b0) $display("[TB] FAIL abort_no_record got %0b want 0", bus.wb_valid);
    else passCount++;
    doLoad(32'h0000_0040, 4'h1);
    checkCount++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_7777)
      $display("[TB] FAIL abort_ram got v=%0b d=%h want 1/00007777", bus.wb_valid, bus.wb_data);
    else passCount++;
  endtask

  task automatic test_wrap;
    doStore(32'hFFFF_FF05, 16'h5555);
    checkCount++;
    if (bus.wb_data !== 32'hFFFF_FF05) $display("[TB] FAIL wrap_st_data got %h want ffffff05", bus.wb_data);
    else passCount++;
    doLoad(32'h0000_0005, 4'h9);
    checkCount++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_5555 || bus.wb_dest !== 4'h9)
      $display("[TB] FAIL wrap_load got v=%0b d=%h dest=%h want 1/00005555/9",
               bus.wb_valid, bus.wb_data, bus.wb_dest);
    else passCount++;
  endtask

  initial begin
    passCount    = 0;
    checkCount   = 0;
    rst          = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_rd    = '0;
    bus.ex_rb    = '0;
    bus.ex_ctrl  = '0;
    $display("[TB] starting mem_stage bench");
    test_reset();
    test_passthrough();
    test_store_load_fwd();
    test_store_priority();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the MIPS CPU, directly downstream of the Execute stage. It consumes Execute's registered result (`RD_out`), store data (`RB_out`) and control word (`CTRL_EX`), and owns an internal single-port synchronous data RAM. It performs loads and stores, passes ALU and multiplier results through, and presents one registered write-back record per accepted operation. A ready/valid handshake stalls Execute while a load completes.

## Interface

**Parameters**
- `DATA_W`, 16: RAM word width and store-data width.
- `ADDR_W`, 8: RAM address width; depth is 2^ADDR_W words.

**Ports**
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `ex_valid`  in  1  Execute presents a valid operation.
- `ex_rd`  in  32  result from Execute; bits [ADDR_W-1:0] are also the memory address.
- `ex_rb`  in  DATA_W  store data.
- `ex_ctrl`  in  7  control word:
  - [6] `reg_write`
  - [5] `mem_read`
  - [4] `mem_write`
  - [3:0] destination register
- `mem_ready`  out  1  stage can accept an operation this cycle.
- `wb_valid`  out  1  write-back record valid, one-cycle pulse.
- `wb_data`  out  32  write-back value.
- `wb_dest`  out  4  destination register.
- `wb_reg_write`  out  1  register-file write enable for this record.

## Operation

**Accept rule**
- An operation is accepted at a rising edge where `ex_valid`=1, `mem_ready`=1 and `rst`=1.
- When `mem_ready`=0, `ex_valid` is ignored. Execute holds its outputs until it sees `mem_ready`=1.

**FSM**
- States: IDLE and LOAD_WAIT.
- `mem_ready` = (state==IDLE), decoded directly from the state register.
- IDLE → LOAD_WAIT on an accepted load. All other accepts stay in IDLE.
- LOAD_WAIT → IDLE unconditionally on the next edge.

**Operation classes at accept (priority: mem_write > mem_read > pass-through)**
- Store (`mem_write`=1):
  - `ram[ex_rd[ADDR_W-1:0]] <= ex_rb`.
  - The record has `wb_reg_write`=0 regardless of ctrl[6], and `wb_data`=`ex_rd`.
  - `mem_read` is ignored when `mem_write`=1.
- Load (`mem_read`=1, `mem_write`=0):
  - Latch the address, dest and `reg_write`, and issue the RAM read.
  - The record carries `wb_data` = zero-extended RAM word (upper 32-DATA_W bits = 0).
- Pass-through (both 0): `wb_data`=`ex_rd`, `wb_dest`=ctrl[3:0], `wb_reg_write`=ctrl[6].

**Width and address rules**
- Bits [31:ADDR_W] of `ex_rd` are ignored for addressing. Addresses wrap modulo 2^ADDR_W.
- The RAM has no reset. Its contents are undefined until written.

**Write-back outputs**
- `wb_data`, `wb_dest` and `wb_reg_write` are registered.
- They update only when a record is produced and hold their value otherwise.

## Timing

**Latency (edge 0 = accept edge)**
- Pass-through and store: record valid after edge 0, i.e. `wb_valid`=1 for the cycle following edge 0.
- Load: `mem_ready`=0 for the cycle after edge 0. The record is valid after edge 1.

**Throughput**
- Pass-through and store: one per cycle.
- Load: one per 2 cycles.

**`wb_valid`**
- High for exactly one cycle per accepted operation.
- Low in any cycle with no record, including the stall cycle of a load.

**Ordering**
- Records leave in acceptance order.
- A load accepted the cycle after a store to the same address returns the newly stored value.

**Reset (`rst`=0 at an edge)**
- State → IDLE.
- `wb_valid`, `wb_data`, `wb_dest`, `wb_reg_write` → 0.
- `mem_ready`=1 from the first cycle after the reset edge.

**Reset boundary cases**
- Reset during LOAD_WAIT aborts the load; no record is ever produced for it.
- A store presented in a reset cycle does not write the RAM.
- `ex_valid`=1 during reset is not accepted.

## Test plan

1. Reset, then pass-through with `ex_rd`=0x0001_2345 and ctrl={1,0,0,4'h3} → one cycle later `wb_valid`=1, `wb_data`=0x0001_2345, `wb_dest`=3, `wb_reg_write`=1; next cycle `wb_valid`=0.
2. Store `ex_rb`=0xBEEF at `ex_rd`=0x0000_0110 (address 0x10), then load with `ex_rd`=0x10, ctrl={1,1,0,4'h5} on the very next cycle → `mem_ready`=0 for one cycle, then `wb_data`=0x0000_BEEF, `wb_dest`=5, `wb_reg_write`=1.
3. Store with ctrl={1,1,1,4'h7}, address 0x20, data 0x1234 → record has `wb_reg_write`=0; a later load from 0x20 returns 0x0000_1234.
4. Hold `ex_valid`=1 with three back-to-back loads from addresses 0x01/0x02/0x03 holding 0xA/0xB/0xC → `mem_ready` alternates 1,0; exactly three `wb_valid` pulses, two cycles apart, with data 0xA, 0xB, 0xC in order.
5. Accept a load, assert `rst`=0 during LOAD_WAIT → no `wb_valid` pulse; all outputs 0 and `mem_ready`=1 after the reset edge; a store presented during reset leaves the prior RAM contents readable unchanged.
6. Address wrap: store 0x5555 with `ex_rd`=0xFFFF_FF05, then load with `ex_rd`=0x05 → `wb_data`=0x0000_5555.
